// File: rtl/audiodac_tone_sequencer.sv
// Test-tone sequencer for the LUT sine generator: paces generator reads with a sample-rate
// divider, optionally gates samples into on/off bursts, and drops samples on downstream stall.
module audiodac_tone_sequencer #(
    parameter int unsigned BW       = 16,
    parameter int unsigned LUT_SIZE = 6,
    parameter int unsigned DIV_W    = 12,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic [LUT_SIZE-2:0]     step_i,
    input  logic [CNT_W-1:0]        burst_on_i,
    input  logic [CNT_W-1:0]        burst_off_i,
    input  logic signed [BW-1:0]    sine_data_i,
    output logic                    sine_rd_o,
    output logic                    sine_en_o,
    output logic [LUT_SIZE-2:0]     sine_step_o,
    output logic signed [BW-1:0]    data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        overrun_cnt_o
);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDrain} state_e;

    state_e                 r_state;
    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [LUT_SIZE-2:0]    r_step;
    logic [CNT_W-1:0]       r_burst_on;
    logic [CNT_W-1:0]       r_burst_off;
    logic [CNT_W-1:0]       r_burst_cnt;
    logic [CNT_W-1:0]       r_overrun;
    logic signed [BW-1:0]   r_data;
    logic                   r_valid;
    logic                   r_sine_en;

    logic                   w_running;
    logic                   w_tick;
    logic                   w_accept;
    logic                   w_slot_free;
    logic                   w_load;
    logic                   w_burst_mode;
    logic                   w_burst_done;
    logic [CNT_W-1:0]       w_burst_len;

    // stop_i suppresses the tick of its own cycle so nothing loads while shutting down
    assign w_running    = ((r_state == StOn) || (r_state == StOff)) && !stop_i;
    assign w_tick       = w_running && (r_div_cnt == r_div);
    assign w_accept     = r_valid && ready_i;
    assign w_slot_free  = !r_valid || ready_i;
    assign w_load       = w_tick && w_slot_free;
    assign w_burst_mode = (r_burst_on != '0) && (r_burst_off != '0);
    assign w_burst_len  = (r_state == StOn) ? r_burst_on : r_burst_off;
    assign w_burst_done = w_burst_mode && ((r_burst_cnt + CNT_W'(1)) == w_burst_len);

    // Generator only advances on sine loads, so the phase freezes during gaps and stalls
    assign sine_rd_o     = w_load && (r_state == StOn) && !rst_i;
    assign sine_en_o     = r_sine_en;
    assign sine_step_o   = r_step;
    assign data_o        = r_data;
    assign valid_o       = r_valid;
    assign busy_o        = (r_state != StIdle);
    assign overrun_cnt_o = r_overrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_div_cnt   <= '0;
            r_step      <= '0;
            r_burst_on  <= '0;
            r_burst_off <= '0;
            r_burst_cnt <= '0;
            r_overrun   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sine_en   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (start_i && !stop_i) begin
                        r_div       <= div_i;
                        r_step      <= step_i;
                        r_burst_on  <= burst_on_i;
                        r_burst_off <= burst_off_i;
                        r_div_cnt   <= '0;
                        r_burst_cnt <= '0;
                        r_overrun   <= '0;
                        r_sine_en   <= 1'b1;
                        r_state     <= StOn;
                    end
                end
                StOn, StOff: begin
                    if (stop_i) begin
                        r_sine_en <= 1'b0;
                        r_state   <= (r_valid && !ready_i) ? StDrain : StIdle;
                    end else begin
                        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
                        if (w_load) begin
                            r_valid <= 1'b1;
                            r_data  <= (r_state == StOn) ? sine_data_i : '0;
                            if (w_burst_done) begin
                                r_burst_cnt <= '0;
                                r_state     <= (r_state == StOn) ? StOff : StOn;
                            end else if (w_burst_mode) begin
                                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                            end
                        end else if (w_tick && (r_overrun != '1)) begin
                            r_overrun <= r_overrun + CNT_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_accept) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_audiodac_tone_sequencer.sv
// Bench for audiodac_tone_sequencer: a behavioural sine LUT generator, table-driven runs checked
// through a sample scoreboard, and hand-written stall, drain, start/stop and reset sequences.
module tb_audiodac_tone_sequencer;

    logic               clk;
    logic               rst_i;
    logic               start_i;
    logic               stop_i;
    logic [11:0]        div_i;
    logic [4:0]         step_i;
    logic [7:0]         burst_on_i;
    logic [7:0]         burst_off_i;
    logic signed [15:0] sine_data;
    logic               sine_rd_o;
    logic               sine_en_o;
    logic [4:0]         sine_step_o;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic               ready_i;
    logic               busy_o;
    logic [7:0]         overrun_cnt_o;

    audiodac_tone_sequencer #(
        .BW       (16),
        .LUT_SIZE (6),
        .DIV_W    (12),
        .CNT_W    (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .div_i         (div_i),
        .step_i        (step_i),
        .burst_on_i    (burst_on_i),
        .burst_off_i   (burst_off_i),
        .sine_data_i   (sine_data),
        .sine_rd_o     (sine_rd_o),
        .sine_en_o     (sine_en_o),
        .sine_step_o   (sine_step_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .busy_o        (busy_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural generator: presents lut[phase], advances by step on each read strobe
    logic signed [15:0] lut [64];
    logic [5:0]         gen_phase;
    always @(posedge clk) begin
        if (rst_i) gen_phase <= '0;
        else if (sine_rd_o) gen_phase <= gen_phase + 6'(sine_step_o);
    end
    assign sine_data = lut[gen_phase];

    typedef struct {
        logic [11:0] div;
        logic [4:0]  step;
        logic [7:0]  on;
        logic [7:0]  off;
        int          n;
    } vec_t;

    vec_t               vecs [5];
    logic signed [15:0] sb [$];
    logic [5:0]         exp_phase;
    int                 n_cmp;
    int                 n_err;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_phase = '0;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  per;
        int  last;
        int  j;
        bit  burst;
        bit  exp_rd;
        bit  exp_valid;
        logic signed [15:0] exp_d;
        per   = int'(v.div) + 1;
        last  = v.n * per;
        burst = (v.on != 0) && (v.off != 0);
        for (int k = 0; k < v.n; k++) begin
            if (!burst || (k % (int'(v.on) + int'(v.off))) < int'(v.on)) begin
                sb.push_back(lut[exp_phase]);
                exp_phase = exp_phase + 6'(v.step);
            end else begin
                sb.push_back(16'sd0);
            end
        end
        @(negedge clk);
        div_i = v.div; step_i = v.step; burst_on_i = v.on; burst_off_i = v.off;
        ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c == last + 1) stop_i = 1'b1;
            #1;
            if (c == 1) begin
                chk($sformatf("v%0d_step", idx), int'(sine_step_o), int'(v.step));
                chk($sformatf("v%0d_en", idx), int'(sine_en_o), 1);
                chk($sformatf("v%0d_busy", idx), int'(busy_o), 1);
            end
            exp_rd = 1'b0;
            if (c <= last && (c % per) == 0) begin
                j = c / per - 1;
                exp_rd = burst ? ((j % (int'(v.on) + int'(v.off))) < int'(v.on)) : 1'b1;
            end
            chk($sformatf("v%0d_rd_c%0d", idx, c), int'(sine_rd_o), int'(exp_rd));
            exp_valid = (c >= 2) && (((c - 1) % per) == 0);
            chk($sformatf("v%0d_valid_c%0d", idx, c), int'(valid_o), int'(exp_valid));
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty_c%0d", idx, c), 1, 0);
                end else begin
                    exp_d = sb.pop_front();
                    chk($sformatf("v%0d_data_c%0d", idx, c), int'(data_o), int'(exp_d));
                end
            end
        end
        @(negedge clk);
        stop_i = 1'b0;
        #1;
        chk($sformatf("v%0d_idle_busy", idx), int'(busy_o), 0);
        chk($sformatf("v%0d_idle_en", idx), int'(sine_en_o), 0);
        chk($sformatf("v%0d_idle_valid", idx), int'(valid_o), 0);
        chk($sformatf("v%0d_sb_left", idx), sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{div: 12'd3, step: 5'd1, on: 8'd0, off: 8'd0, n: 6};
        vecs[1] = '{div: 12'd1, step: 5'd1, on: 8'd4, off: 8'd2, n: 12};
        vecs[2] = '{div: 12'd0, step: 5'd3, on: 8'd0, off: 8'd0, n: 5};
        vecs[3] = '{div: 12'd2, step: 5'd2, on: 8'd2, off: 8'd0, n: 4};
        vecs[4] = '{div: 12'd0, step: 5'd1, on: 8'd1, off: 8'd1, n: 6};
        for (int k = 0; k < 64; k++) begin
            lut[k] = 16'($rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * k / 64.0)));
        end
        n_cmp = 0; n_err = 0;
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
        div_i = '0; step_i = '0; burst_on_i = '0; burst_off_i = '0;
        exp_phase = '0;

        do_reset();
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_rd", int'(sine_rd_o), 0);
        chk("rst_en", int'(sine_en_o), 0);
        chk("rst_step", int'(sine_step_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ovr", int'(overrun_cnt_o), 0);

        // Generator phase carries over between runs
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Stall: drops are counted, data held, no generator reads, then resume without phase skip
        do_reset();
        div_i = 12'd0; step_i = 5'd1; burst_on_i = 8'd0; burst_off_i = 8'd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("stall_first_rd", int'(sine_rd_o), 1);
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            ready_i = 1'b0;
            #1;
            chk($sformatf("stall_rd_c%0d", c), int'(sine_rd_o), 0);
            chk($sformatf("stall_data_c%0d", c), int'(data_o), int'(lut[0]));
        end
        @(negedge clk);
        ready_i = 1'b1;
        #1;
        chk("stall_ovr10", int'(overrun_cnt_o), 10);
        chk("resume_rd", int'(sine_rd_o), 1);
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        chk("resume_data", int'(data_o), int'(lut[1]));
        chk("resume_valid", int'(valid_o), 1);
        repeat (300) @(negedge clk);
        #1;
        chk("ovr_saturate", int'(overrun_cnt_o), 255);
        chk("sat_data_held", int'(data_o), int'(lut[1]));

        // Stop with a pending sample: drain until accepted
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        #1;
        chk("drain_busy", int'(busy_o), 1);
        chk("drain_en", int'(sine_en_o), 0);
        chk("drain_valid", int'(valid_o), 1);
        chk("drain_data", int'(data_o), int'(lut[1]));
        @(negedge clk);
        ready_i = 1'b1;
        #1;
        chk("drain_rd", int'(sine_rd_o), 0);
        @(negedge clk);
        #1;
        chk("drain_done_busy", int'(busy_o), 0);
        chk("drain_done_valid", int'(valid_o), 0);

        // start and stop together in IDLE, then a restart attempt while running
        do_reset();
        div_i = 12'd4; step_i = 5'd1; burst_on_i = 8'd0; burst_off_i = 8'd0;
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        #1;
        chk("ss_busy", int'(busy_o), 0);
        chk("ss_en", int'(sine_en_o), 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 3) begin
                div_i = 12'd0; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            #1;
            chk($sformatf("restart_rd_c%0d", c), int'(sine_rd_o), int'(c == 5 || c == 10));
        end
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        #1;
        chk("restart_stop_busy", int'(busy_o), 0);

        // Reset mid-burst with a stalled sample
        do_reset();
        div_i = 12'd1; step_i = 5'd5; burst_on_i = 8'd4; burst_off_i = 8'd2;
        ready_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_valid", int'(valid_o), 1);
        chk("pre_rst_ovr", int'(overrun_cnt_o), 1);
        chk("pre_rst_step", int'(sine_step_o), 5);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_data", int'(data_o), 0);
        chk("mid_rst_ovr", int'(overrun_cnt_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_en", int'(sine_en_o), 0);
        chk("mid_rst_step", int'(sine_step_o), 0);
        chk("mid_rst_rd", int'(sine_rd_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audiodac_tone_sequencer.md
Name: audiodac_tone_sequencer

Overview:
Controller that sequences the LUT sine generator for audio DAC test tones. A programmable sample-rate divider issues read strobes to the generator and captures each sample into a valid/ready output register feeding the DAC datapath. Optional tone-burst gating alternates N sine samples with M zero samples. Drops and counts samples when the downstream consumer stalls.

Parameters:
BW, 16, sample bitwidth (matches sine generator BW)
LUT_SIZE, 6, sine generator LUT address width; step field is LUT_SIZE-1 bits
DIV_W, 12, width of sample-period divider
CNT_W, 8, width of burst on/off sample counters and overrun counter

Ports:
clk_i  in  1  clock, posedge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  pulse: latch config, begin sequencing (ignored unless IDLE)
stop_i  in  1  pulse: end sequencing; wins over start_i in the same cycle
div_i  in  DIV_W  sample period = div_i+1 clk cycles
step_i  in  LUT_SIZE-1  LUT step, passed to generator
burst_on_i  in  CNT_W  samples per sine burst
burst_off_i  in  CNT_W  zero samples between bursts; 0 = continuous
sine_data_i  in  BW signed  generator output
sine_rd_o  out  1  generator advance strobe (one cycle)
sine_en_o  out  1  generator enable
sine_step_o  out  LUT_SIZE-1  latched step to generator
data_o  out  BW signed  output sample
valid_o  out  1  data_o valid
ready_i  in  1  downstream accepts data_o when valid_o&ready_i
busy_o  out  1  state != IDLE
overrun_cnt_o  out  CNT_W  dropped-sample count, saturating

Behaviour:
- Reset (rst_i high at posedge): state IDLE; data_o=0, valid_o=0, sine_rd_o=0, sine_en_o=0, sine_step_o=0, overrun_cnt_o=0, all counters 0, latched config 0.
- States: IDLE, ON, OFF, DRAIN.
- IDLE: start_i & !stop_i -> latch div/step/burst_on/burst_off, clear divider, burst counter and overrun_cnt_o; next state ON.
- Burst mode active iff latched burst_on!=0 and burst_off!=0; otherwise ON is continuous.
- Divider: counts 0..div each cycle in ON/OFF; tick asserted in the cycle count==div, count wraps to 0. First tick occurs div+1 cycles after entering ON. div=0 -> tick every cycle.
- sine_en_o=1 in ON and OFF; sine_step_o = latched step (held through DRAIN/IDLE).
- Tick in ON, output slot free (valid_o=0, or valid_o&ready_i this cycle): sine_rd_o=1 this cycle (combinational from tick); data_o<=sine_data_i, valid_o<=1 next edge. Latency: sample at tick cycle t visible at t+1.
- Tick in OFF, slot free: data_o<=0, valid_o<=1; sine_rd_o=0 (phase frozen during gap).
- Tick with slot occupied (valid_o&!ready_i): sample dropped, sine_rd_o=0, overrun_cnt_o+=1 saturating at 2^CNT_W-1; burst counter not advanced; data_o unchanged.
- Burst counter increments per loaded sample; ON->OFF after burst_on loads, OFF->ON after burst_off loads, counter clears on each switch.
- Handshake: data_o stable while valid_o&!ready_i; valid_o clears after accept unless a new sample loads same edge.
- stop_i in ON/OFF: no further ticks or loads; sine_en_o=0 next cycle; -> DRAIN if valid_o&!ready_i, else IDLE. DRAIN -> IDLE on accept. stop_i in IDLE/DRAIN ignored. start_i outside IDLE ignored.
- Generator phase is not reset by this block; successive runs continue from last LUT position.
- rst_i mid-operation: immediate return to reset values regardless of pending handshake.

Test Plan:
- Reset then start with div=3, step=1, burst_off=0, ready_i=1 -> sine_rd_o pulses every 4 cycles, first at cycle 4 after start; data_o follows consecutive LUT values (0, 3211, 6392 ... for BW=16), valid_o one cycle each.
- div=0, ready_i=0 for 10 cycles after first sample -> data_o holds first sample, overrun_cnt_o=10, no sine_rd_o pulses; ready_i=1 resumes with next LUT entry (no phase skip).
- burst_on=4, burst_off=2, div=1, ready_i=1 -> repeating pattern of 4 sine samples then 2 zeros, sine_rd_o only on the 4 sine samples.
- stop_i while valid_o=1, ready_i=0 -> busy_o stays 1 (DRAIN), sine_en_o=0; ready_i=1 -> sample accepted, IDLE next cycle, busy_o=0.
- start_i and stop_i same cycle in IDLE -> stays IDLE; start_i while running with new div -> ignored, period unchanged.
- rst_i asserted mid-burst with valid_o=1 -> next cycle all outputs 0, overrun_cnt_o=0, IDLE.
